// File: rtl/load_unit.sv
// load_unit: load path between execute and writeback.
// Accepts a load request, performs one word-aligned read on the data-memory
// req/gnt/rvalid interface, then extracts and extends the addressed
// byte/halfword/word and returns it as a one-cycle response.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (ready only in IDLE)
//   req_addr_i, req_funct3_i,
//   req_rd_i                     byte address, RV32I load funct3, dest reg
//   mem_req_o, mem_addr_o        memory read request, word-aligned address
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                  memory grant, read-valid, read data
//   rsp_valid_o                  one-cycle response pulse
//   rsp_data_o, rsp_rd_o,
//   rsp_err_o                    extended data, dest reg, error code
//                                (00 ok, 01 misaligned, 10 illegal, 11 timeout)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a new request
// REQ    | mem_req_o high, waiting for grant
// WAIT   | granted, waiting for read data
// RESP   | rsp_valid_o high for this single cycle
module load_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [4:0]            req_rd_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_data_o,
    output logic [4:0]            rsp_rd_o,
    output logic [1:0]            rsp_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    // Counter runs 0..TIMEOUT_CYCLES-1 over the REQ+WAIT cycles; the cycle in
    // which it holds the last value is the final one allowed.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt;

    logic        illegal_f3;
    logic        misaligned;
    logic [1:0]  accept_err;
    logic        timeout;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign req_ready_o = (state == S_IDLE);
    assign timeout     = (cnt == CNT_LAST);

    always_comb begin
        illegal_f3 = 1'b1;
        misaligned = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b100: illegal_f3 = 1'b0;
            3'b001, 3'b101: begin
                illegal_f3 = 1'b0;
                misaligned = req_addr_i[0];
            end
            3'b010: begin
                illegal_f3 = 1'b0;
                misaligned = (req_addr_i[1:0] != 2'b00);
            end
            default: illegal_f3 = 1'b1;
        endcase
        // Illegal funct3 wins over misalignment.
        if (illegal_f3)
            accept_err = 2'b10;
        else if (misaligned)
            accept_err = 2'b01;
        else
            accept_err = 2'b00;
    end

    always_comb begin
        shifted = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00: load_data = funct3_q[2] ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = funct3_q[2] ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            // Only LW reaches here; it is word-aligned so the shift is zero.
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            rd_q        <= 5'd0;
            cnt         <= 8'd0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 32'd0;
            rsp_rd_o    <= 5'd0;
            rsp_err_o   <= 2'b00;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        off_q    <= req_addr_i[1:0];
                        funct3_q <= req_funct3_i;
                        rd_q     <= req_rd_i;
                        cnt      <= 8'd0;
                        if (accept_err != 2'b00) begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= 32'd0;
                            rsp_rd_o    <= req_rd_i;
                            rsp_err_o   <= accept_err;
                        end else begin
                            state      <= S_REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                S_REQ: begin
                    // A grant in the final allowed cycle does not complete
                    // the load, so the timeout still applies.
                    if (timeout) begin
                        state       <= S_RESP;
                        mem_req_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= 32'd0;
                        rsp_rd_o    <= rd_q;
                        rsp_err_o   <= 2'b11;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (mem_gnt_i) begin
                            state     <= S_WAIT;
                            mem_req_o <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= load_data;
                        rsp_rd_o    <= rd_q;
                        rsp_err_o   <= 2'b00;
                    end else if (timeout) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= 32'd0;
                        rsp_rd_o    <= rd_q;
                        rsp_err_o   <= 2'b11;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: begin
                    state     <= S_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: fixed vector table, hand-written multi-cycle
// sequences (reset abort, back-to-back loads, stray rvalid) and randomized
// loads checked against an arithmetic reference model.
module tb_load_unit;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [2:0]  req_funct3_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic [1:0]  rsp_err_o;

    int total = 0;
    int bad   = 0;

    load_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_funct3_i(req_funct3_i), .req_rd_i(req_rd_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          g;
        int          r;
        logic [1:0]  err;
        logic [31:0] data;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Reference model from the load rules: size/legality table, modular
    // alignment test, and extension by arithmetic on integers.
    function automatic void model(input logic [31:0] addr, input logic [2:0] f3,
                                  input logic [31:0] rdata, input int g, input int r,
                                  output logic [1:0] err, output logic [31:0] data,
                                  output int lat);
        int size;
        longint val;
        longint span;
        size = 0;
        if (f3 == 3'd0 || f3 == 3'd4) size = 1;
        if (f3 == 3'd1 || f3 == 3'd5) size = 2;
        if (f3 == 3'd2) size = 4;
        data = 32'd0;
        if (size == 0) begin
            err = 2'b10; lat = 1;
        end else if ((addr % size) != 0) begin
            err = 2'b01; lat = 1;
        end else if ((g + 1) + (r + 1) > TMO) begin
            err = 2'b11; lat = TMO + 1;
        end else begin
            err  = 2'b00;
            lat  = g + r + 3;
            span = 64'd1 << (8 * size);
            val  = longint'(rdata / (32'd1 << (8 * (addr % 4)))) % span;
            if (f3 < 3'd4 && size < 4 && val >= span / 2) val = val - span;
            data = val[31:0];
        end
    endfunction

    // One load: request, memory answering gnt in REQ cycle g+1 and rvalid
    // r cycles into WAIT, then check response timing and content.
    task automatic do_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input int g, input int r, input logic [1:0] eerr,
                           input logic [31:0] edata, input int elat);
        int pulses;
        int pcyc;
        logic [31:0] pdata;
        logic [4:0]  prd;
        logic [1:0]  perr;
        logic        expect_mem;
        for (int i = 0; i < 20 && !req_ready_o; i++) begin
            @(posedge clk_i); #1;
        end
        chk({nm, "_ready"}, 32'(req_ready_o), 32'd1);
        req_addr_i = addr; req_funct3_i = f3; req_rd_i = rd; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        expect_mem = (eerr == 2'b00 || eerr == 2'b11);
        pulses = 0; pcyc = 0; pdata = 0; prd = 0; perr = 0;
        for (int k = 1; k <= elat + 2; k++) begin
            mem_gnt_i    = (k == g + 1);
            mem_rvalid_i = (k == g + 2 + r);
            mem_rdata_i  = mem_rvalid_i ? rdata : $urandom;
            @(negedge clk_i);
            if (k == 1) begin
                chk({nm, "_memreq"}, 32'(mem_req_o), 32'(expect_mem));
                if (expect_mem) chk({nm, "_memaddr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
            end
            if (rsp_valid_o) begin
                pulses++;
                pcyc = k; pdata = rsp_data_o; prd = rsp_rd_o; perr = rsp_err_o;
            end
            @(posedge clk_i); #1;
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk({nm, "_pulses"}, 32'(pulses), 32'd1);
        chk({nm, "_lat"}, 32'(pcyc), 32'(elat));
        chk({nm, "_data"}, pdata, edata);
        chk({nm, "_err"}, 32'(perr), 32'(eerr));
        chk({nm, "_rd"}, 32'(prd), 32'(rd));
    endtask

    task automatic stray_rvalid(input string nm);
        int pulses;
        pulses = 0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk_i);
            if (rsp_valid_o) pulses++;
            @(posedge clk_i); #1;
        end
        mem_rvalid_i = 1'b0;
        chk(nm, 32'(pulses), 32'd0);
    endtask

    vec_t tbl[14];
    vec_t bb[3];

    initial begin
        logic [1:0]  merr;
        logic [31:0] mdata;
        int          mlat;
        logic [31:0] ra;
        logic [2:0]  rf;
        logic [31:0] rw;
        int          rg;
        int          rr;
        int          pulses;
        int          pcyc[3];
        int          idx, reqcnt, wcnt, nrv;
        logic        in_wait, accepted, req_was;

        tbl[0]  = '{32'h1003, 3'd0, 5'd5,  32'h80FF1234, 0, 0,  2'b00, 32'hFFFFFF80, 3};
        tbl[1]  = '{32'h2002, 3'd5, 5'd6,  32'h8001ABCD, 0, 0,  2'b00, 32'h00008001, 3};
        tbl[2]  = '{32'h2002, 3'd1, 5'd7,  32'h8001ABCD, 0, 0,  2'b00, 32'hFFFF8001, 3};
        tbl[3]  = '{32'h2000, 3'd2, 5'd8,  32'h8001ABCD, 0, 0,  2'b00, 32'h8001ABCD, 3};
        tbl[4]  = '{32'h3002, 3'd2, 5'd9,  32'h11111111, 0, 0,  2'b01, 32'h0,        1};
        tbl[5]  = '{32'h3000, 3'd3, 5'd10, 32'h11111111, 0, 0,  2'b10, 32'h0,        1};
        tbl[6]  = '{32'h3001, 3'd3, 5'd11, 32'h11111111, 0, 0,  2'b10, 32'h0,        1};
        tbl[7]  = '{32'h1001, 3'd4, 5'd12, 32'h80FF1234, 1, 1,  2'b00, 32'h00000012, 5};
        tbl[8]  = '{32'h1001, 3'd5, 5'd13, 32'h80FF1234, 0, 0,  2'b01, 32'h0,        1};
        tbl[9]  = '{32'h4000, 3'd2, 5'd14, 32'h55555555, 1, 99, 2'b11, 32'h0,        5};
        tbl[10] = '{32'h4004, 3'd2, 5'd15, 32'h12345678, 1, 1,  2'b00, 32'h12345678, 5};
        tbl[11] = '{32'h4008, 3'd2, 5'd16, 32'h12345678, 3, 0,  2'b11, 32'h0,        5};
        tbl[12] = '{32'h0010, 3'd0, 5'd17, 32'h0000007F, 0, 2,  2'b00, 32'h0000007F, 5};
        tbl[13] = '{32'h0010, 3'd7, 5'd31, 32'h0000007F, 0, 0,  2'b10, 32'h0,        1};

        bb[0] = '{32'h0100, 3'd2, 5'd1, 32'hCAFEBABE, 1, 1, 2'b00, 32'hCAFEBABE, 5};
        bb[1] = '{32'h0101, 3'd4, 5'd2, 32'h0000A500, 1, 1, 2'b00, 32'h000000A5, 5};
        bb[2] = '{32'h0102, 3'd1, 5'd3, 32'h87650000, 1, 1, 2'b00, 32'hFFFF8765, 5};

        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = 0; req_funct3_i = 0; req_rd_i = 0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 0;
        #12;
        chk("rst_ready",   32'(req_ready_o), 32'd1);
        chk("rst_memreq",  32'(mem_req_o),   32'd0);
        chk("rst_memaddr", mem_addr_o,       32'd0);
        chk("rst_valid",   32'(rsp_valid_o), 32'd0);
        chk("rst_data",    rsp_data_o,       32'd0);
        chk("rst_rd",      32'(rsp_rd_o),    32'd0);
        chk("rst_err",     32'(rsp_err_o),   32'd0);
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 14; i++) begin
            do_load($sformatf("vec%0d", i), tbl[i].addr, tbl[i].f3, tbl[i].rd, tbl[i].rdata,
                    tbl[i].g, tbl[i].r, tbl[i].err, tbl[i].data, tbl[i].lat);
            if (i == 9) stray_rvalid("stray_after_timeout");
        end

        // Reset in REQ (ph 0) and in WAIT (ph 1).
        for (int ph = 0; ph < 2; ph++) begin
            req_addr_i = 32'h5000; req_funct3_i = 3'd2; req_rd_i = 5'd7; req_valid_i = 1'b1;
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
            if (ph == 1) begin
                mem_gnt_i = 1'b1;
                @(posedge clk_i); #1;
                mem_gnt_i = 1'b0;
            end
            #2 rst_i = 1'b1;
            #1;
            chk($sformatf("rst%0d_memreq", ph), 32'(mem_req_o), 32'd0);
            chk($sformatf("rst%0d_ready", ph), 32'(req_ready_o), 32'd1);
            @(negedge clk_i); rst_i = 1'b0;
            @(posedge clk_i); #1;
            stray_rvalid($sformatf("rst%0d_no_rsp", ph));
            do_load($sformatf("after_rst%0d", ph), 32'h6002, 3'd5, 5'd9, 32'hBEEF0000,
                    0, 0, 2'b00, 32'h0000BEEF, 3);
        end

        // Back-to-back with req_valid_i held high, gnt and rvalid each one cycle late.
        idx = 0; reqcnt = 0; wcnt = 0; nrv = 0; in_wait = 1'b0; pulses = 0;
        pcyc[0] = 0; pcyc[1] = 0; pcyc[2] = 0;
        for (int c = 0; c < 60 && pulses < 3; c++) begin
            if (idx < 3) begin
                req_addr_i = bb[idx].addr; req_funct3_i = bb[idx].f3;
                req_rd_i = bb[idx].rd; req_valid_i = 1'b1;
            end else begin
                req_valid_i = 1'b0;
            end
            req_was      = mem_req_o;
            mem_gnt_i    = mem_req_o && (reqcnt == 1);
            mem_rvalid_i = in_wait && (wcnt == 1);
            mem_rdata_i  = (mem_rvalid_i && nrv < 3) ? bb[nrv].rdata : $urandom;
            accepted     = req_ready_o && req_valid_i;
            @(negedge clk_i);
            if (rsp_valid_o) begin
                chk($sformatf("bb%0d_data", pulses), rsp_data_o, bb[pulses].data);
                chk($sformatf("bb%0d_rd", pulses), 32'(rsp_rd_o), 32'(bb[pulses].rd));
                chk($sformatf("bb%0d_err", pulses), 32'(rsp_err_o), 32'd0);
                pcyc[pulses] = c;
                pulses++;
            end
            @(posedge clk_i); #1;
            if (accepted) idx++;
            if (mem_rvalid_i) begin
                in_wait = 1'b0; nrv++;
            end else if (in_wait) begin
                wcnt++;
            end
            if (mem_gnt_i) begin
                in_wait = 1'b1; wcnt = 0; reqcnt = 0;
            end else if (req_was) begin
                reqcnt++;
            end
        end
        req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("bb_pulses", 32'(pulses), 32'd3);
        chk("bb_first", 32'(pcyc[0]), 32'd5);
        chk("bb_gap1", 32'(pcyc[1] - pcyc[0]), 32'd6);
        chk("bb_gap2", 32'(pcyc[2] - pcyc[1]), 32'd6);
        stray_rvalid("bb_no_extra");

        // Randomized loads against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom & 32'h0000_FFFF;
            rf = 3'($urandom_range(0, 7));
            rw = $urandom;
            rg = $urandom_range(0, 3);
            rr = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
            model(ra, rf, rw, rg, rr, merr, mdata, mlat);
            do_load($sformatf("rnd%0d", i), ra, rf, 5'($urandom), rw, rg, rr, merr, mdata, mlat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/load_unit.md
# load_unit

Load path of the riscv-jedro-1 core, sitting between execute and writeback. It accepts a load request (address, funct3, destination register) and performs one word-aligned read on the data-memory request/grant/rvalid interface. It then selects the addressed byte, halfword or word, sign- or zero-extends it to 32 bits, and delivers it to writeback as a single-cycle response. Misaligned accesses, illegal funct3 values and memory timeouts are reported through an error code and never reach the register file as valid data.

## Interface
- ADDR_WIDTH, 32, data-memory address width
- TIMEOUT_CYCLES, 255, maximum cycles in REQ+WAIT before a timeout error (1..255)

- clk_i  in  1  clock; one clock domain
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  load request valid
- req_ready_o  out  1  unit idle and able to accept a request
- req_addr_i  in  ADDR_WIDTH  byte address
- req_funct3_i  in  3  RV32I load funct3
- req_rd_i  in  5  destination register index
- mem_req_o  out  1  memory read request
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data word
- rsp_valid_o  out  1  one-cycle response pulse to writeback
- rsp_data_o  out  32  extended load data
- rsp_rd_o  out  5  destination register index
- rsp_err_o  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- req_ready_o = (state == IDLE).
- A request is accepted when req_valid_i && req_ready_o. On acceptance, latch addr[1:0], funct3 and rd, and clear the timeout counter.
- Legal funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. All others are illegal and produce err 10.
- Misaligned access produces err 01:
  - LH/LHU with addr[0] = 1.
  - LW with addr[1:0] != 00.
  - Byte loads are never misaligned.
  - Illegal funct3 takes precedence over misaligned.
- Error at acceptance: go IDLE→RESP. No memory access occurs. rsp_data_o = 0.
- Otherwise go IDLE→REQ, with mem_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
- REQ: mem_req_o = 1 until mem_gnt_i. On grant go →WAIT, and mem_req_o drops in the next cycle.
- WAIT: mem_rvalid_i moves the FSM to RESP and computes rsp_data_o from mem_rdata_i:
  - Shift right by 8·addr[1:0].
  - Byte loads take bits [7:0]; halfword loads take bits [15:0].
  - funct3[2] = 0 sign-extends from the top bit of the selected field; funct3[2] = 1 zero-extends.
  - LW passes the word through unchanged.
- mem_rvalid_i is only sampled in WAIT. In IDLE, REQ and RESP it is ignored.
- Timeout: the counter increments every cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES without completion, go →RESP with err 11 and rsp_data_o = 0. mem_req_o drops. A late rvalid is ignored.
- RESP: rsp_valid_o = 1 for exactly one cycle, then →IDLE.
- rsp_data_o, rsp_rd_o and rsp_err_o are registered and hold their values until the next response.
- Reset values: state IDLE, req_ready_o 1, mem_req_o 0, mem_addr_o 0, rsp_valid_o 0, rsp_data_o 0, rsp_rd_o 0, rsp_err_o 00, counter 0.
- Reset mid-operation: immediate return to IDLE and mem_req_o deasserts asynchronously. No response is produced for the aborted load. Memory responses arriving after reset are ignored.

## Timing
- Acceptance at edge T: REQ in cycle T+1 with mem_req_o high.
- Best case: gnt in T+1, rvalid in T+2, rsp_valid_o in T+3. Load latency is 3 cycles.
- Error at acceptance: rsp_valid_o in T+1.
- Each extra gnt or rvalid wait cycle adds one cycle of latency.
- Maximum throughput: one load per 4 cycles, because req_ready_o is low in REQ, WAIT and RESP.
- All outputs except req_ready_o come from flops. req_ready_o is a decode of the state register.

## Test plan
- LB at addr 0x1003, rdata 0x80FF1234, gnt and rvalid with no wait → rsp_valid in T+3, data 0xFFFFFF80, err 00, rd echoed, mem_addr_o 0x1000.
- LHU at addr 0x2002, rdata 0x8001ABCD → data 0x00008001. LH at the same address → 0xFFFF8001. LW at 0x2000 → 0x8001ABCD.
- LW at 0x3002 → no mem_req_o, rsp_valid in T+1, err 01, data 0. funct3 011 → err 10.
- TIMEOUT_CYCLES = 4, gnt after 2 cycles, rvalid never → err 11 at the 4th REQ+WAIT cycle. A subsequent stray rvalid in IDLE produces no response.
- rst_i pulsed during WAIT → mem_req_o 0, req_ready_o 1 immediately. rvalid arriving afterwards produces no rsp_valid. The next load completes normally.
- req_valid_i held high for three back-to-back loads with 1-cycle gnt/rvalid delays → exactly three rsp_valid pulses, in order, each followed by one IDLE cycle.
